// File: rtl/ws2811_led_chain.sv
// WS2811/WS2812 chain driver: streams NUM_LEDS GRB words MSB-first and then a latch gap, forever.
// A free-running divider runs alongside it and produces the slow o_div_clk.
module ws2811_led_chain #(
    parameter  int NUM_LEDS     = 41,
    parameter  int SYSTEM_CLOCK = 50_000_000,
    parameter  int DIV_N        = 6_000_000,
    localparam int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [ADDR_W-1:0] o_address,
    input  logic [7:0]        i_red,
    input  logic [7:0]        i_green,
    input  logic [7:0]        i_blue,
    output logic              o_data,
    output logic              o_div_clk
);
    localparam int T_BIT   = SYSTEM_CLOCK / 800_000;
    localparam int T0H     = SYSTEM_CLOCK / 2_500_000;
    localparam int T1H     = SYSTEM_CLOCK / 1_250_000;
    localparam int T_LATCH = SYSTEM_CLOCK / 1_000_000 * 60;
    localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = (DIV_N > 1) ? $clog2(DIV_N) : 1;

    typedef enum logic {LATCH, SEND} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          bit_q, bit_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         shift_q, shift_d;
    logic                capture;
    logic [CNT_W-1:0]    hi_len;
    logic [DIV_W-1:0]    div_cnt_q;
    logic                div_clk_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= LATCH;
            cnt_q   <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
        end
    end

    // The address wraps to 0 when the last LED is captured. An address of 0 at the end
    // of a word therefore marks the final LED of the frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        capture = 1'b0;
        case (state_q)
            LATCH: begin
                if (cnt_q == CNT_W'(T_LATCH - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND;
                    capture = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == CNT_W'(T_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        if (addr_q == '0) state_d = LATCH;
                        else              capture = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = LATCH;
        endcase
        if (capture) begin
            shift_d = {i_green, i_red, i_blue};
            addr_d  = (addr_q == ADDR_W'(NUM_LEDS - 1)) ? '0 : addr_q + 1'b1;
        end
    end

    // o_data is decoded from registers, so asserting reset pulls the line low at once.
    assign hi_len    = shift_q[23] ? CNT_W'(T1H) : CNT_W'(T0H);
    assign o_data    = (state_q == SEND) && (cnt_q < hi_len);
    assign o_address = addr_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt_q <= '0;
            div_clk_q <= 1'b0;
        end else if (div_cnt_q == DIV_W'(DIV_N - 1)) begin
            div_cnt_q <= '0;
            div_clk_q <= ~div_clk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign o_div_clk = div_clk_q;
endmodule

// File: tb/tb_ws2811_led_chain.sv
// Bench for ws2811_led_chain at 50 MHz: a 2-LED chain (dut0) and a 1-LED chain (dut1), both with DIV_N=3.
module tb_ws2811_led_chain;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] addr0, addr1;
    logic       data0, data1, div0, div1;
    logic [7:0] g_mem [2];
    logic [7:0] r_mem [2];
    logic [7:0] b_mem [2];
    logic [7:0] g1, r1, b1;
    int         nchk = 0;
    int         nfail = 0;

    always #10 clk = ~clk;

    ws2811_led_chain #(.NUM_LEDS(2), .SYSTEM_CLOCK(50_000_000), .DIV_N(3)) dut0 (
        .i_clk(clk), .i_reset(rst), .o_address(addr0),
        .i_red(r_mem[addr0]), .i_green(g_mem[addr0]), .i_blue(b_mem[addr0]),
        .o_data(data0), .o_div_clk(div0));

    ws2811_led_chain #(.NUM_LEDS(1), .SYSTEM_CLOCK(50_000_000), .DIV_N(3)) dut1 (
        .i_clk(clk), .i_reset(rst), .o_address(addr1),
        .i_red(r1), .i_green(g1), .i_blue(b1),
        .o_data(data1), .o_div_clk(div1));

    typedef struct {
        logic [7:0]  g0, r0, b0, g1, r1, b1;
        logic [23:0] w0, w1;
    } row_t;

    function automatic logic dsel(input bit sel);
        return sel ? data1 : data0;
    endfunction
    function automatic logic asel(input bit sel);
        return sel ? addr1[0] : addr0[0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts low cycles up to the next rising edge of o_data, with a bound.
    task automatic measure_latch(input bit sel, input string tag);
        int n = 0;
        bit aok = 1;
        while (dsel(sel) == 1'b0 && n < 10000) begin
            if (asel(sel) != 1'b0) aok = 0;
            n++;
            @(negedge clk);
        end
        chk({tag, " latch_len"}, n, 3000);
        chk({tag, " latch_addr0"}, int'(aok), 1);
    endtask

    // Samples n bits of 62 cycles each and decodes each bit from its high time.
    task automatic measure_bits(input bit sel, input int n, input logic ea,
                                output logic [23:0] w, output int bad, output bit aok);
        w = '0; bad = 0; aok = 1;
        for (int b = 0; b < n; b++) begin
            int h = 0;
            repeat (62) begin
                if (dsel(sel)) h++;
                if (asel(sel) != ea) aok = 0;
                @(negedge clk);
            end
            w = {w[22:0], (h == 40)};
            if (h != 20 && h != 40) bad++;
        end
    endtask

    task automatic check_led(input bit sel, input logic ea, input logic [23:0] exp,
                             input string tag);
        logic [23:0] w;
        int bad;
        bit aok;
        measure_bits(sel, 24, ea, w, bad, aok);
        chk({tag, " word"}, int'(w), int'(exp));
        chk({tag, " bad_widths"}, bad, 0);
        chk({tag, " addr"}, int'(aok), 1);
    endtask

    task automatic set_leds(input row_t r);
        g_mem[0] = r.g0; r_mem[0] = r.r0; b_mem[0] = r.b0;
        g_mem[1] = r.g1; r_mem[1] = r.r1; b_mem[1] = r.b1;
    endtask

    initial begin
        row_t rows [4];
        row_t rm;
        logic [23:0] w;
        int bad;
        bit aok;

        rows[0] = '{g0:8'h80, r0:8'h00, b0:8'h01, g1:8'hff, r1:8'h00, b1:8'haa, w0:24'h800001, w1:24'hff00aa};
        rows[1] = '{g0:8'h00, r0:8'hff, b0:8'h00, g1:8'h12, r1:8'h34, b1:8'h56, w0:24'h00ff00, w1:24'h123456};
        rows[2] = '{g0:8'h00, r0:8'h00, b0:8'h00, g1:8'hff, r1:8'hff, b1:8'hff, w0:24'h000000, w1:24'hffffff};
        rows[3] = '{g0:8'ha5, r0:8'h5a, b0:8'h3c, g1:8'h01, r1:8'h80, b1:8'hff, w0:24'ha55a3c, w1:24'h0180ff};
        set_leds(rows[0]);
        g1 = 8'h5a; r1 = 8'hc3; b1 = 8'h0f;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst data0", int'(data0), 0);
        chk("rst addr0", int'(addr0), 0);
        chk("rst div0", int'(div0), 0);
        chk("rst data1", int'(data1), 0);
        chk("rst addr1", int'(addr1), 0);
        chk("rst div1", int'(div1), 0);

        // Divider, DIV_N=3: three samples low, three high, and so on.
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("div0 k=%0d", k), int'(div0), (k / 3) % 2);
            @(negedge clk);
        end

        // Single-LED chain: the address stays 0 and each latch is followed by one 24-bit word.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure_latch(1'b1, "n1 f0");
        check_led(1'b1, 1'b0, 24'h5ac30f, "n1 led0");
        measure_latch(1'b1, "n1 f1");
        check_led(1'b1, 1'b0, 24'h5ac30f, "n1 led0b");

        // Two-LED chain driven from the vector table.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_leds(rows[i]);
            measure_latch(1'b0, $sformatf("row%0d", i));
            check_led(1'b0, 1'b1, rows[i].w0, $sformatf("row%0d led0", i));
            check_led(1'b0, 1'b0, rows[i].w1, $sformatf("row%0d led1", i));
        end

        // LED0 colour changes while LED0 is being sent: the change must not show until the next frame.
        rm = '{g0:8'h11, r0:8'h22, b0:8'h33, g1:8'h0f, r1:8'hf0, b1:8'h81, w0:24'h112233, w1:24'h0ff081};
        set_leds(rm);
        measure_latch(1'b0, "mid f0");
        fork
            begin
                repeat (600) @(negedge clk);
                g_mem[0] = 8'h44; r_mem[0] = 8'h55; b_mem[0] = 8'h66;
            end
        join_none
        check_led(1'b0, 1'b1, 24'h112233, "mid led0 old");
        check_led(1'b0, 1'b0, 24'h0ff081, "mid led1");
        measure_latch(1'b0, "mid f1");
        check_led(1'b0, 1'b1, 24'h445566, "mid led0 new");

        // Reset asserted in bit 10 of LED1.
        measure_bits(1'b0, 10, 1'b0, w, bad, aok);
        chk("pre-rst led1 bits", int'(w[9:0]), int'(10'b0000111111));
        repeat (5) @(negedge clk);
        chk("pre-rst data high", int'(data0), 1);
        rst = 1'b1;
        #1;
        chk("rst async data0", int'(data0), 0);
        chk("rst async addr0", int'(addr0), 0);
        repeat (4) @(negedge clk);
        chk("rst hold div0", int'(div0), 0);
        rst = 1'b0;
        measure_latch(1'b0, "post-rst");
        check_led(1'b0, 1'b1, 24'h445566, "post-rst led0");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/ws2811_led_chain.md
# ws2811_led_chain

Serial driver for a daisy-chained strip of WS2811/WS2812 RGB LEDs, plus a free-running slow clock divider for colour-update logic. It continuously streams one frame per refresh: every LED's 24-bit colour, then a latch gap. It requests colours from an external colour store by LED index, so the store can be a simple registered array. It sits between the breakout's LED colour logic and the single neopixel data pin.

## Interface
- `NUM_LEDS`, 41: LEDs in the chain (≥1).
- `SYSTEM_CLOCK`, 50_000_000: `i_clk` frequency in Hz; all protocol timings derive from it.
- `DIV_N`, 6_000_000: half-period of `o_div_clk`, in `i_clk` cycles (≥1).
- `ADDR_W` (derived, not overridable): max(1, ceil(log2(NUM_LEDS))).

- `i_clk`, in, 1: system clock. One clock domain; all logic on its rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-high.
- `o_address`, out, ADDR_W: index of the next LED whose colour will be captured.
- `i_red`, in, 8: red for LED `o_address`.
- `i_green`, in, 8: green for LED `o_address`.
- `i_blue`, in, 8: blue for LED `o_address`.
- `o_data`, out, 1: serial line to the first LED's DIN.
- `o_div_clk`, out, 1: divided clock, period 2·DIV_N.

## Operation
- Derived cycle counts use integer division:
  - T_BIT = SYSTEM_CLOCK/800_000.
  - T0H = SYSTEM_CLOCK/2_500_000.
  - T1H = SYSTEM_CLOCK/1_250_000.
  - T_LATCH = SYSTEM_CLOCK/1_000_000·60.
  - At 50 MHz these are 62, 20, 40 and 3000.
- States:
  - LATCH: `o_data` low for T_LATCH cycles.
  - SEND: shifts out 24 bits per LED, for NUM_LEDS LEDs.
  - Transitions: LATCH → SEND → LATCH. The cycle repeats forever.
- Word format: shift register = {green, red, blue}, MSB first (G7 first, B0 last).
- Bit waveform:
  - Each bit lasts exactly T_BIT cycles.
  - `o_data` is high for T1H cycles (bit=1) or T0H cycles (bit=0) from bit start, then low for the rest of the bit.
- Capture and addressing:
  - On the last cycle of LATCH, the colour inputs are captured into the shift register, and `o_address` advances to 1 (or wraps to 0 if NUM_LEDS=1).
  - On the last cycle of LED k's 24th bit, the inputs are captured for LED k+1 and `o_address` advances. There is no gap between LEDs.
  - After the last LED's final bit, `o_address` is 0 and the state is LATCH.
  - Inputs only need to be stable on the capture cycle. `o_address` is stable for ≥24·T_BIT cycles before each capture (≥T_LATCH for LED 0).
- Divider:
  - Counter runs 0..DIV_N−1 and wraps.
  - `o_div_clk` toggles on each wrap.
  - Independent of the LED engine.

## Timing
- Reset values: `o_data`=0, `o_address`=0, `o_div_clk`=0, all counters 0, state=LATCH.
- After reset deasserts, a full T_LATCH low period precedes the first bit.
- Reset mid-frame: `o_data` drops low asynchronously. The frame is abandoned and restarts with a full latch.
- Frame period = NUM_LEDS·24·T_BIT + T_LATCH cycles. For the defaults this is 64 008 cycles.
- The first rising edge of `o_div_clk` occurs DIV_N cycles after reset release.
- Colour changes on inputs take effect at the next capture of that LED index. There is no tearing within one LED's 24 bits.

## Test plan
- SYSTEM_CLOCK=50 MHz, NUM_LEDS=2; reset, then release; LED0 colour G=0x80,R=0x00,B=0x01 → `o_data` low 3000 cycles, then first bit high 40/low 22, next 7 bits high 20/low 42, …, B0 high 40.
- Same setup: measure `o_address` → 0 during latch, 1 during LED0's bits, 0 during LED1's bits and the next latch; frame repeats every 2·24·62+3000 = 5976 cycles.
- Change LED0 colour mid-transmission of LED0 → the current frame is unchanged; the new value appears in the next frame.
- Assert `i_reset` during bit 10 of LED1 → `o_data`=0 immediately; after release, 3000 low cycles, then LED0 restarts.
- DIV_N=3 → `o_div_clk` 0 for 3 cycles, then 1 for 3 cycles, period 6; held at 0 while in reset.
- NUM_LEDS=1 → `o_address` constant 0; frame = 1488+3000 cycles.
